bsh_arb: RTL

Round-robin arbiter and sequencer that shares one 32-bit barrel rotator (bsh_32) among NUM_REQ requesters. The rotator sits outside this block: it drives the rotator's data/dir/sh inputs from registered operands and captures its combinational result. It returns each result, tagged with the requester index, on a single valid/ready response channel. Only one operation is in flight at a time.

---
 rtl/bsh_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bsh_arb.sv
// -----------------------------------------------------------------------------
// bsh_arb - round-robin arbiter / sequencer for one shared 32-bit rotator.
//
// NUM_REQ requesters compete for a single external barrel rotator (bsh_32).
// The winner's operand, direction and amount are registered onto the bsh_*
// outputs. One cycle later the rotator's combinational result is captured.
// It is then returned on a single valid/ready response channel, tagged with
// the index of the requester that issued it. Only one operation is in flight.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester request valid            [NUM_REQ]
//   req_ready       per-requester accept, one-hot or zero   [NUM_REQ]
//   req_data        packed operands, 32 bits per requester  [32*NUM_REQ]
//   req_dir         rotate direction (1 = right, 0 = left)  [NUM_REQ]
//   req_sh          packed amounts, 5 bits per requester    [5*NUM_REQ]
//   bsh_data_in     registered operand to the rotator       [32]
//   bsh_dir         registered direction to the rotator
//   bsh_sh          registered amount to the rotator        [5]
//   bsh_data_out    rotator result (combinational)          [32]
//   rsp_valid       response valid
//   rsp_ready       response accept
//   rsp_data        rotated result                          [32]
//   rsp_id          index of the issuing requester          [IDW]
//   busy            high whenever not idle
// -----------------------------------------------------------------------------
module bsh_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_dir,
    input  logic [5*NUM_REQ-1:0]    req_sh,
    output logic [31:0]             bsh_data_in,
    output logic                    bsh_dir,
    output logic [4:0]              bsh_sh,
    input  logic [31:0]             bsh_data_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [31:0]    r_bsh_data;
    logic           r_bsh_dir;
    logic [4:0]     r_bsh_sh;
    logic [31:0]    r_rsp_data;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_valid;

    logic           w_grant_vld;
    logic [IDW-1:0] w_grant_idx;
    logic [IDW-1:0] w_idx;
    logic [31:0]    w_sel_data;
    logic           w_sel_dir;
    logic [4:0]     w_sel_sh;

    // Round-robin search: start one past the last winner and wrap, so the
    // most recently served requester has the lowest priority next time.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_grant_vld && req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_sel_data = '0;
        w_sel_dir  = 1'b0;
        w_sel_sh   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_sel_data = req_data[32*i +: 32];
                w_sel_dir  = req_dir[i];
                w_sel_sh   = req_sh[5*i +: 5];
            end
        end
    end

    // Ready is only offered from IDLE, and is held off while reset is
    // asserted so no requester believes it was accepted by a block in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && w_grant_vld) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= IDW'(NUM_REQ - 1);
            r_bsh_data  <= '0;
            r_bsh_dir   <= 1'b0;
            r_bsh_sh    <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_bsh_data <= w_sel_data;
                        r_bsh_dir  <= w_sel_dir;
                        r_bsh_sh   <= w_sel_sh;
                        r_rsp_id   <= w_grant_idx;
                        r_rr_ptr   <= w_grant_idx;
                        r_state    <= ST_ROT;
                    end
                end
                ST_ROT: begin
                    // Operands have been stable on bsh_* for a full cycle,
                    // so the rotator output is settled here.
                    r_rsp_data  <= bsh_data_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bsh_data_in = r_bsh_data;
    assign bsh_dir     = r_bsh_dir;
    assign bsh_sh      = r_bsh_sh;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_id      = r_rsp_id;
    assign busy        = (r_state != ST_IDLE);

endmodule
